// File: rtl/fpu_pkg.sv
// ============================================================================
//  Module      : fpu_pkg
//  Description : Shared widths, result classes and operand unpacking for the
//                single-precision add/sub pre-alignment path.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package fpu_pkg;

  localparam int FORMAT_LENGTH             = 32;
  localparam int EXPONENT_LENGTH           = 8;
  localparam int FRACTION_LENGTH           = 23;
  localparam int NORMALIZE_MANTISSA_LENGTH = 24;
  localparam int GRS_LENGTH                = 3;

  // Past this shift distance every mantissa bit lands below the round bit.
  localparam int                         SAT_BITS  = 27;
  localparam logic [EXPONENT_LENGTH-1:0] SAT_SHIFT = 8'd27;

  typedef logic [1:0] fp_class_t;
  localparam fp_class_t ZERO     = 2'b00;
  localparam fp_class_t NAN      = 2'b01;
  localparam fp_class_t INFINITY = 2'b10;
  localparam fp_class_t NORMAL   = 2'b11;

  typedef struct packed {
    logic                                 sign;
    logic [EXPONENT_LENGTH-1:0]           exp;
    logic [NORMALIZE_MANTISSA_LENGTH-1:0] man;
  } fp_unpacked_t;

  // Denormals flush to zero: a zero exponent yields a zero mantissa.
  function automatic fp_unpacked_t fp_unpack(input logic [FORMAT_LENGTH-1:0] op);
    fp_unpacked_t u;
    u.sign = op[FORMAT_LENGTH-1];
    u.exp  = op[FORMAT_LENGTH-2 -: EXPONENT_LENGTH];
    u.man  = (u.exp != '0) ? {1'b1, op[FRACTION_LENGTH-1:0]}
                           : {NORMALIZE_MANTISSA_LENGTH{1'b0}};
    return u;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_align_shifter.sv
// ============================================================================
//  Module      : fpu_align_shifter
//  Description : Combinational mantissa right shifter with guard/round/sticky.
//                Sticky OR-tree present only with FPU_PRE_ALIGN_STICKY_EN.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module fpu_align_shifter
  import fpu_pkg::*;
(
  input  logic [NORMALIZE_MANTISSA_LENGTH-1:0] i_man,
  input  logic [EXPONENT_LENGTH-1:0]           i_diff,
  output logic [NORMALIZE_MANTISSA_LENGTH-1:0] o_man,
  output logic [GRS_LENGTH-1:0]                o_grs
);

`ifdef FPU_PRE_ALIGN_STICKY_EN
  localparam int EXT_W = NORMALIZE_MANTISSA_LENGTH + SAT_BITS;

  logic [EXT_W-1:0] w_ext;
  assign w_ext = {i_man, {SAT_BITS{1'b0}}} >> i_diff;

  always_comb begin
    o_man = w_ext[EXT_W-1 -: NORMALIZE_MANTISSA_LENGTH];
    o_grs = {w_ext[SAT_BITS-1], w_ext[SAT_BITS-2], |w_ext[SAT_BITS-3:0]};
    if (i_diff >= SAT_SHIFT) begin
      o_man = '0;
      o_grs = {2'b00, |i_man};
    end
  end
`else
  // Only guard and round are kept; large shifts naturally drain to zero.
  localparam int EXT_W = NORMALIZE_MANTISSA_LENGTH + 2;

  logic [EXT_W-1:0] w_ext;
  assign w_ext = {i_man, 2'b00} >> i_diff;

  assign o_man = w_ext[EXT_W-1 -: NORMALIZE_MANTISSA_LENGTH];
  assign o_grs = {w_ext[1:0], 1'b0};
`endif

endmodule

`default_nettype wire

// File: rtl/fpu_pre_align.sv
// ============================================================================
//  Module      : fpu_pre_align
//  Description : Two-stage add/sub pre-alignment: unpack/classify/order, then
//                align smaller mantissa. Option: FPU_PRE_ALIGN_STICKY_EN.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module fpu_pre_align
  import fpu_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [FORMAT_LENGTH-1:0]             op_a,
  input  logic [FORMAT_LENGTH-1:0]             op_b,
  input  logic                                 op_sub,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [EXPONENT_LENGTH-1:0]           exp_o,
  output logic [NORMALIZE_MANTISSA_LENGTH-1:0] man_l_o,
  output logic [NORMALIZE_MANTISSA_LENGTH-1:0] man_s_o,
  output logic [GRS_LENGTH-1:0]                grs_o,
  output logic                                 eff_sub_o,
  output logic                                 sign_o,
  output fp_class_t                            class_o
);

  fp_unpacked_t w_a, w_b;
  logic         w_sign_b_eff, w_a_larger, w_eff_sub, w_sign;
  logic         w_nan_a, w_nan_b, w_inf_a, w_inf_b;
  fp_class_t    w_class;
  logic [NORMALIZE_MANTISSA_LENGTH-1:0] w_man_l, w_man_s;
  logic [EXPONENT_LENGTH-1:0]           w_exp_l, w_exp_s;

  logic                                 r_s1_valid, r_s1_sign, r_s1_eff_sub;
  logic [NORMALIZE_MANTISSA_LENGTH-1:0] r_s1_man_l, r_s1_man_s;
  logic [EXPONENT_LENGTH-1:0]           r_s1_diff, r_s1_exp;
  fp_class_t                            r_s1_class;
  logic                                 r_s2_valid;

  logic                                 w_s2_free;
  logic [NORMALIZE_MANTISSA_LENGTH-1:0] w_man_s_al;
  logic [GRS_LENGTH-1:0]                w_grs;

  assign w_s2_free = !r_s2_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_s2_free;
  assign out_valid = r_s2_valid;

  assign w_a          = fp_unpack(op_a);
  assign w_b          = fp_unpack(op_b);
  assign w_sign_b_eff = w_b.sign ^ op_sub;
  assign w_eff_sub    = w_a.sign ^ w_sign_b_eff;

  // Exponents equal: hidden bits match, so comparing whole mantissas orders fractions.
  assign w_a_larger = (w_a.exp > w_b.exp) || ((w_a.exp == w_b.exp) && (w_a.man >= w_b.man));
  assign w_man_l    = w_a_larger ? w_a.man : w_b.man;
  assign w_man_s    = w_a_larger ? w_b.man : w_a.man;
  assign w_exp_l    = w_a_larger ? w_a.exp : w_b.exp;
  assign w_exp_s    = w_a_larger ? w_b.exp : w_a.exp;

  assign w_nan_a = (&w_a.exp) && (|w_a.man[FRACTION_LENGTH-1:0]);
  assign w_nan_b = (&w_b.exp) && (|w_b.man[FRACTION_LENGTH-1:0]);
  assign w_inf_a = (&w_a.exp) && !(|w_a.man[FRACTION_LENGTH-1:0]);
  assign w_inf_b = (&w_b.exp) && !(|w_b.man[FRACTION_LENGTH-1:0]);

  always_comb begin
    w_class = NORMAL;
    w_sign  = w_a_larger ? w_a.sign : w_sign_b_eff;
    if (w_nan_a || w_nan_b || (w_inf_a && w_inf_b && w_eff_sub)) begin
      w_class = NAN;
    end else if (w_inf_a || w_inf_b) begin
      w_class = INFINITY;
      w_sign  = w_inf_a ? w_a.sign : w_sign_b_eff;
    end else if ((w_a.exp == '0) && (w_b.exp == '0)) begin
      w_class = ZERO;
      w_sign  = w_a.sign & w_sign_b_eff;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_man_l   <= '0;
      r_s1_man_s   <= '0;
      r_s1_diff    <= '0;
      r_s1_exp     <= '0;
      r_s1_sign    <= 1'b0;
      r_s1_eff_sub <= 1'b0;
      r_s1_class   <= ZERO;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_man_l   <= w_man_l;
        r_s1_man_s   <= w_man_s;
        r_s1_diff    <= w_exp_l - w_exp_s;
        r_s1_exp     <= w_exp_l;
        r_s1_sign    <= w_sign;
        r_s1_eff_sub <= w_eff_sub;
        r_s1_class   <= w_class;
      end
    end
  end

  fpu_align_shifter u_shifter (
    .i_man  (r_s1_man_s),
    .i_diff (r_s1_diff),
    .o_man  (w_man_s_al),
    .o_grs  (w_grs)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      exp_o      <= '0;
      man_l_o    <= '0;
      man_s_o    <= '0;
      grs_o      <= '0;
      eff_sub_o  <= 1'b0;
      sign_o     <= 1'b0;
      class_o    <= ZERO;
    end else if (w_s2_free) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        exp_o     <= r_s1_exp;
        man_l_o   <= r_s1_man_l;
        man_s_o   <= w_man_s_al;
        grs_o     <= w_grs;
        eff_sub_o <= r_s1_eff_sub;
        sign_o    <= r_s1_sign;
        class_o   <= r_s1_class;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fpu_pre_align.sv
// ============================================================================
//  Module      : tb_fpu_pre_align
//  Description : Scoreboard bench for fpu_pre_align with hand-derived vectors.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_fpu_pre_align;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        op_sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  exp_o;
  logic [23:0] man_l_o, man_s_o;
  logic [2:0]  grs_o;
  logic        eff_sub_o, sign_o;
  logic [1:0]  class_o;

  fpu_pre_align dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .exp_o     (exp_o),
    .man_l_o   (man_l_o),
    .man_s_o   (man_s_o),
    .grs_o     (grs_o),
    .eff_sub_o (eff_sub_o),
    .sign_o    (sign_o),
    .class_o   (class_o)
  );

  always #5 clk = ~clk;

`ifdef FPU_PRE_ALIGN_STICKY_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  typedef struct {
    logic [31:0] a, b;
    logic        sub;
    logic [7:0]  exp;
    logic [23:0] ml, ms;
    logic [2:0]  grs;
    logic        eff, sign;
    logic [1:0]  cls;
    bit          chk_data, chk_sign;
  } vec_t;

  vec_t vecs[14];
  vec_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pushed = 0;
  int   n_out    = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic sub,
                              input logic [7:0] e, input logic [23:0] ml, input logic [23:0] ms,
                              input logic [2:0] grs, input logic eff, input logic sign,
                              input logic [1:0] cls, input bit cd, input bit cs);
    vec_t v;
    v.a = a; v.b = b; v.sub = sub; v.exp = e; v.ml = ml; v.ms = ms; v.grs = grs;
    v.eff = eff; v.sign = sign; v.cls = cls; v.chk_data = cd; v.chk_sign = cs;
    return v;
  endfunction

  task automatic send(input int idx);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    op_a     = vecs[idx].a;
    op_b     = vecs[idx].b;
    op_sub   = vecs[idx].sub;
    forever begin
      #1;
      if (in_ready) break;
      @(negedge clk);
      waited++;
      if (waited > 200) begin
        chk("send_timeout", 64'(waited), 0);
        break;
      end
    end
    if (waited <= 200) begin
      sb_q.push_back(vecs[idx]);
      n_pushed++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    #1;
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        vec_t e;
        e = sb_q.pop_front();
        n_out++;
        chk("class", 64'(class_o), 64'(e.cls));
        if (e.chk_sign) chk("sign", 64'(sign_o), 64'(e.sign));
        if (e.chk_data) begin
          chk("exp",   64'(exp_o),     64'(e.exp));
          chk("man_l", 64'(man_l_o),   64'(e.ml));
          chk("man_s", 64'(man_s_o),   64'(e.ms));
          chk("grs",   64'(grs_o),     64'(e.grs));
          chk("eff",   64'(eff_sub_o), 64'(e.eff));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [62:0] snap;
    int          bound;

    vecs[0]  = mk(32'h3F800000, 32'h3F800000, 0, 8'h7F, 24'h800000, 24'h800000, 3'b000, 0, 0, 2'b11, 1, 1);
    vecs[1]  = mk(32'h3F000000, 32'h3F800000, 1, 8'h7F, 24'h800000, 24'h400000, 3'b000, 1, 1, 2'b11, 1, 1);
    vecs[2]  = mk(32'h3F800000, 32'h33800000, 0, 8'h7F, 24'h800000, 24'h000000, 3'b100, 0, 0, 2'b11, 1, 1);
    vecs[3]  = mk(32'h3F800000, 32'h32800000, 0, 8'h7F, 24'h800000, 24'h000000, {2'b00, STK}, 0, 0, 2'b11, 1, 1);
    vecs[4]  = mk(32'h3F800000, 32'h32000000, 0, 8'h7F, 24'h800000, 24'h000000, {2'b00, STK}, 0, 0, 2'b11, 1, 1);
    vecs[5]  = mk(32'h40000000, 32'h3F800003, 0, 8'h80, 24'h800000, 24'h400001, 3'b100, 0, 0, 2'b11, 1, 1);
    vecs[6]  = mk(32'h41000000, 32'h3F800007, 0, 8'h82, 24'h800000, 24'h100000, {2'b11, STK}, 0, 0, 2'b11, 1, 1);
    vecs[7]  = mk(32'hBF800000, 32'hBF800000, 1, 8'h7F, 24'h800000, 24'h800000, 3'b000, 1, 1, 2'b11, 1, 1);
    vecs[8]  = mk(32'h3F800000, 32'h00000001, 0, 8'h7F, 24'h800000, 24'h000000, 3'b000, 0, 0, 2'b11, 1, 1);
    vecs[9]  = mk(32'h7F800000, 32'hFF800000, 0, 8'h00, 24'h0, 24'h0, 3'b000, 0, 0, 2'b01, 0, 0);
    vecs[10] = mk(32'h7F800000, 32'h3F800000, 0, 8'h00, 24'h0, 24'h0, 3'b000, 0, 0, 2'b10, 0, 1);
    vecs[11] = mk(32'h00000000, 32'h80000000, 0, 8'h00, 24'h0, 24'h0, 3'b000, 1, 0, 2'b00, 1, 1);
    vecs[12] = mk(32'h7FC00000, 32'h3F800000, 0, 8'h00, 24'h0, 24'h0, 3'b000, 0, 0, 2'b01, 0, 0);
    vecs[13] = mk(32'h3F800000, 32'hFF800000, 0, 8'h00, 24'h0, 24'h0, 3'b000, 0, 1, 2'b10, 0, 1);

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_in_ready",  64'(in_ready),  1);
    chk("rst_data", {exp_o, man_l_o, man_s_o, grs_o, eff_sub_o, sign_o, class_o}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Latency: visible on the second edge after the transfer edge
    send(0);
    #1;
    chk("lat_early", 64'(out_valid), 0);
    @(negedge clk);
    #1;
    chk("lat_due", 64'(out_valid), 1);

    // Back-to-back at full rate
    for (int i = 1; i < 14; i++) send(i);

    // Backpressure: two accepted, then held
    repeat (4) @(negedge clk);
    out_ready = 1'b0;
    send(5);
    send(6);
    #1;
    chk("bp_in_ready",  64'(in_ready),  0);
    chk("bp_out_valid", 64'(out_valid), 1);
    snap = {exp_o, man_l_o, man_s_o, grs_o, eff_sub_o, sign_o, class_o};
    repeat (3) @(negedge clk);
    #1;
    chk("bp_hold", {exp_o, man_l_o, man_s_o, grs_o, eff_sub_o, sign_o, class_o}, snap);
    fork
      begin
        repeat (2) @(negedge clk);
        out_ready = 1'b1;
      end
      begin
        send(7);
        send(2);
      end
    join

    bound = 0;
    while (sb_q.size() != 0 && bound < 50) begin
      @(negedge clk);
      bound++;
    end
    #2;
    chk("drain1", 64'(sb_q.size()), 0);
    chk("count1", 64'(n_out), 64'(n_pushed));

    // Reset with both stages full discards in-flight data
    out_ready = 1'b0;
    send(1);
    send(3);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 0);
    chk("mid_rst_in_ready",  64'(in_ready),  1);
    chk("mid_rst_data", {exp_o, man_l_o, man_s_o, grs_o, eff_sub_o, sign_o, class_o}, 0);
    n_pushed -= sb_q.size();
    sb_q.delete();
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);

    // Recovery after reset
    send(1);
    bound = 0;
    while (sb_q.size() != 0 && bound < 50) begin
      @(negedge clk);
      bound++;
    end
    #2;
    chk("drain2", 64'(sb_q.size()), 0);
    chk("count2", 64'(n_out), 64'(n_pushed));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fpu_pre_align.md
Name: fpu_pre_align

Overview:
- Two-stage pipelined pre-alignment unit for the single-precision add/sub datapath.
- Unpacks two IEEE-754 operands, classifies them, and orders them by magnitude.
- Right-shifts the smaller mantissa by the exponent difference and produces guard/round/sticky bits.
- Feeds the mantissa adder, whose sum and cout go to Post_Normalization.

Parameters:
- FORMAT_LENGTH, 32, operand width
- EXPONENT_LENGTH, 8, exponent field width
- FRACTION_LENGTH, 23, fraction field width
- NORMALIZE_MANTISSA_LENGTH, 24, mantissa width including hidden bit

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands this cycle
- op_a  in  32  operand A
- op_b  in  32  operand B
- op_sub  in  1  1 = A-B, 0 = A+B
- out_valid  out  1  aligned result valid
- out_ready  in  1  downstream accepts result
- exp_o  out  8  exponent of larger operand
- man_l_o  out  24  larger mantissa, hidden bit included
- man_s_o  out  24  aligned smaller mantissa
- grs_o  out  3  guard, round, sticky shifted out of man_s_o
- eff_sub_o  out  1  effective subtraction
- sign_o  out  1  sign of larger operand (after op_sub inversion of B)
- class_o  out  2  result class: ZERO 00, NAN 01, INFINITY 10, NORMAL 11

Behaviour:
- Reset: all pipeline valid bits clear; out_valid=0; every data output 0.
- Reset takes priority over any transfer in the same cycle. Reset mid-operation discards in-flight data.
- Handshake:
  - Input transfer on in_valid & in_ready.
  - Output transfer on out_valid & out_ready.
  - Stage S1 loads when empty or when S2 will accept its contents. S2 loads when empty or out_ready.
  - in_ready = !s1_valid | s2_free, where s2_free = !s2_valid | out_ready. Combinational from out_ready; no combinational path from in_valid.
  - Full throughput: one result per cycle when out_ready=1.
  - Latency: 2 cycles from input transfer to out_valid.
  - Outputs stay stable while out_valid & !out_ready.
- S1 (unpack/compare):
  - sign_b_eff = sign_b ^ op_sub.
  - exp==0 is treated as zero; denormals flush to zero. Hidden bit = 1 for exp!=0.
  - A is larger if exp_a>exp_b, or if exponents are equal and frac_a>=frac_b; otherwise operands swap.
  - diff = exp_l - exp_s, 8-bit unsigned.
  - Registers: the larger and smaller mantissas, diff, exp_l, sign_l, eff_sub = sign_a ^ sign_b_eff, class.
- Class rules, in priority order:
  1. Either operand NaN (exp=FF, frac!=0), or inf with inf and eff_sub → NAN.
  2. Either operand inf → INFINITY; sign_o is the sign of the inf.
  3. Both zero → ZERO; sign_o = sign_a & sign_b_eff.
  4. Otherwise → NORMAL.
- S2 (align):
  - man_s_o = man_s >> diff.
  - diff>=27 saturates: man_s_o=0, G=R=0, S=|man_s.
  - G = first bit shifted out; R = second bit shifted out; S = OR of all remaining bits shifted out.
  - diff=0: grs=000.
  - A zero smaller operand yields man_s_o=0 and grs=000.

Optional Feature:
- Macro: FPU_PRE_ALIGN_STICKY_EN.
- Defined: sticky computed as specified above.
- Undefined: grs_o[0] tied to 0 (truncation). Guard and round bits are unchanged; the sticky OR-tree is removed from the design.

Decomposition:
- Package fpu_pkg holds:
  - class localparams ZERO/NAN/INFINITY/NORMAL and a 2-bit typedef fp_class_t;
  - width constants;
  - a typedef struct for unpacked operand (sign, exp, man).
- One sub-module, fpu_align_shifter: combinational 24-bit right shifter with GRS generation, instantiated in S2.

Test Plan:
- 3F800000 + 3F800000, op_sub=0 → after 2 cycles: exp_o=7F, man_l_o=800000, man_s_o=800000, grs_o=000, eff_sub_o=0, class_o=11.
- 3F000000 - 3F800000 → swap: exp_o=7F, man_l_o=800000, man_s_o=400000, grs_o=000, eff_sub_o=1, sign_o=1.
- 3F800000 + 33800000 (diff 24) → man_s_o=0, grs_o=100.
- 3F800000 + 32800000 (diff 26) → man_s_o=0, grs_o=001 with macro, 000 without.
- Specials:
  - 7F800000 + FF800000 → class_o=01.
  - 7F800000 + 3F800000 → class_o=10, sign_o=0.
  - 00000000 + 80000000 → class_o=00, sign_o=0.
- Backpressure: 4 back-to-back ops with out_ready=0 → in_ready drops after 2 accepted; outputs held stable; on out_ready=1 all 4 emerge in order with no loss.
- Reset mid-operation: assert rst with both stages valid → next cycle out_valid=0, in_ready=1, outputs 0.
